// File: rtl/memc_dma_ldst_arb.sv
// Per-lane memory-controller front end: arbitrates the stream-0 DMA and the SIMD
// load/store path onto one single-port SRAM, with a credit-managed DMA read-return queue.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_DMA   | DMA owns the SRAM; write/read round-robin on conflict
// ST_DRAIN | ldst asked for the SRAM; DMA blocked until in-flight reads land
// ST_LDST  | ldst granted; DMA queue keeps returning, no DMA accesses
module memc_dma_ldst_arb #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_RD_LATENCY = 2,
  parameter int RDQ_DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  dma__memc__write_valid,
  input  logic [ADDR_WIDTH-1:0] dma__memc__write_address,
  input  logic [DATA_WIDTH-1:0] dma__memc__write_data,
  output logic                  memc__dma__write_ready,
  input  logic                  dma__memc__read_valid,
  input  logic [ADDR_WIDTH-1:0] dma__memc__read_address,
  input  logic                  dma__memc__read_pause,
  output logic                  memc__dma__read_ready,
  output logic [DATA_WIDTH-1:0] memc__dma__read_data,
  output logic                  memc__dma__read_data_valid,
  input  logic                  ldst__memc__request,
  output logic                  memc__ldst__granted,
  input  logic                  ldst__memc__released,
  input  logic                  ldst__memc__write_valid,
  input  logic [ADDR_WIDTH-1:0] ldst__memc__write_address,
  input  logic [DATA_WIDTH-1:0] ldst__memc__write_data,
  input  logic                  ldst__memc__read_valid,
  input  logic [ADDR_WIDTH-1:0] ldst__memc__read_address,
  output logic [DATA_WIDTH-1:0] memc__ldst__read_data,
  output logic                  memc__ldst__read_data_valid,
  output logic                  memc__sram__cs,
  output logic                  memc__sram__we,
  output logic [ADDR_WIDTH-1:0] memc__sram__addr,
  output logic [DATA_WIDTH-1:0] memc__sram__wdata,
  input  logic [DATA_WIDTH-1:0] sram__memc__rdata
);

  localparam int PW = $clog2(RDQ_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_DMA   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_LDST  = 2'd2;

  logic [1:0]                r_state;
  logic                      r_rr;  // 0 = write side wins the next conflict
  logic [MEM_RD_LATENCY-1:0] r_dtag;
  logic [MEM_RD_LATENCY-1:0] r_ltag;
  logic [CW-1:0]             r_inflight;
  logic [CW-1:0]             r_count;
  logic [PW-1:0]             r_wptr;
  logic [PW-1:0]             r_rptr;
  logic [DATA_WIDTH-1:0]     r_rdq [RDQ_DEPTH];

  logic w_dma, w_ldst, w_credit, w_rd_elig, w_conflict;
  logic w_wr_ready, w_rd_ready, w_dma_wr, w_dma_rd;
  logic w_ldst_rd, w_ldst_wr, w_push, w_pop;

  // Reset gates every combinational output so the SRAM and DMA see nothing during reset.
  assign w_dma      = (r_state == ST_DMA) && !reset_poweron;
  assign w_ldst     = (r_state == ST_LDST) && !reset_poweron;
  assign w_credit   = ({1'b0, r_inflight} + {1'b0, r_count}) < (CW+1)'(RDQ_DEPTH);
  assign w_rd_elig  = dma__memc__read_valid && w_credit;
  assign w_conflict = dma__memc__write_valid && w_rd_elig;
  assign w_wr_ready = w_dma && !(w_conflict && r_rr);
  assign w_rd_ready = w_dma && w_credit && !(w_conflict && !r_rr);
  assign w_dma_wr   = w_wr_ready && dma__memc__write_valid;
  assign w_dma_rd   = w_rd_ready && dma__memc__read_valid;
  assign w_ldst_rd  = w_ldst && ldst__memc__read_valid;
  assign w_ldst_wr  = w_ldst && ldst__memc__write_valid && !ldst__memc__read_valid;
  assign w_push     = r_dtag[MEM_RD_LATENCY-1];
  assign w_pop      = (r_count != '0) && !dma__memc__read_pause;

  assign memc__dma__write_ready      = w_wr_ready;
  assign memc__dma__read_ready       = w_rd_ready;
  assign memc__dma__read_data_valid  = w_pop;
  assign memc__dma__read_data        = (r_count != '0) ? r_rdq[r_rptr] : '0;
  assign memc__ldst__granted         = (r_state == ST_LDST);
  assign memc__ldst__read_data_valid = r_ltag[MEM_RD_LATENCY-1];
  assign memc__ldst__read_data       = r_ltag[MEM_RD_LATENCY-1] ? sram__memc__rdata : '0;

  always_comb begin
    memc__sram__cs    = 1'b0;
    memc__sram__we    = 1'b0;
    memc__sram__addr  = '0;
    memc__sram__wdata = '0;
    if (w_dma_wr) begin
      memc__sram__cs    = 1'b1;
      memc__sram__we    = 1'b1;
      memc__sram__addr  = dma__memc__write_address;
      memc__sram__wdata = dma__memc__write_data;
    end else if (w_dma_rd) begin
      memc__sram__cs    = 1'b1;
      memc__sram__addr  = dma__memc__read_address;
    end else if (w_ldst_rd) begin
      memc__sram__cs    = 1'b1;
      memc__sram__addr  = ldst__memc__read_address;
    end else if (w_ldst_wr) begin
      memc__sram__cs    = 1'b1;
      memc__sram__we    = 1'b1;
      memc__sram__addr  = ldst__memc__write_address;
      memc__sram__wdata = ldst__memc__write_data;
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      r_state <= ST_DMA;
      r_rr    <= 1'b0;
    end else begin
      if (w_conflict && w_dma) r_rr <= ~r_rr;
      case (r_state)
        ST_DMA:   if (ldst__memc__request) r_state <= ST_DRAIN;
        ST_DRAIN: if (r_inflight == '0) r_state <= ST_LDST;
        ST_LDST:  if (ldst__memc__released) r_state <= ST_DMA;
        default:  r_state <= ST_DMA;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      r_dtag     <= '0;
      r_ltag     <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_dtag[0] <= w_dma_rd;
      r_ltag[0] <= w_ldst_rd;
      for (int i = 1; i < MEM_RD_LATENCY; i++) begin
        r_dtag[i] <= r_dtag[i-1];
        r_ltag[i] <= r_ltag[i-1];
      end
      r_inflight <= r_inflight + CW'(w_dma_rd) - CW'(w_push);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Queue storage needs no reset: its output is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_rdq[r_wptr] <= sram__memc__rdata;
  end

endmodule

// File: tb/tb_memc_dma_ldst_arb.sv
// Scoreboard bench for memc_dma_ldst_arb: behavioural SRAM, expected read data queued at
// issue and compared when the DUT returns it.
module tb_memc_dma_ldst_arb;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int L  = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset_poweron;
  logic          dma__memc__write_valid;
  logic [AW-1:0] dma__memc__write_address;
  logic [DW-1:0] dma__memc__write_data;
  logic          memc__dma__write_ready;
  logic          dma__memc__read_valid;
  logic [AW-1:0] dma__memc__read_address;
  logic          dma__memc__read_pause;
  logic          memc__dma__read_ready;
  logic [DW-1:0] memc__dma__read_data;
  logic          memc__dma__read_data_valid;
  logic          ldst__memc__request;
  logic          memc__ldst__granted;
  logic          ldst__memc__released;
  logic          ldst__memc__write_valid;
  logic [AW-1:0] ldst__memc__write_address;
  logic [DW-1:0] ldst__memc__write_data;
  logic          ldst__memc__read_valid;
  logic [AW-1:0] ldst__memc__read_address;
  logic [DW-1:0] memc__ldst__read_data;
  logic          memc__ldst__read_data_valid;
  logic          memc__sram__cs;
  logic          memc__sram__we;
  logic [AW-1:0] memc__sram__addr;
  logic [DW-1:0] memc__sram__wdata;
  logic [DW-1:0] sram__memc__rdata;

  memc_dma_ldst_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_RD_LATENCY(L), .RDQ_DEPTH(D)) dut (
    .clk(clk), .reset_poweron(reset_poweron),
    .dma__memc__write_valid(dma__memc__write_valid),
    .dma__memc__write_address(dma__memc__write_address),
    .dma__memc__write_data(dma__memc__write_data),
    .memc__dma__write_ready(memc__dma__write_ready),
    .dma__memc__read_valid(dma__memc__read_valid),
    .dma__memc__read_address(dma__memc__read_address),
    .dma__memc__read_pause(dma__memc__read_pause),
    .memc__dma__read_ready(memc__dma__read_ready),
    .memc__dma__read_data(memc__dma__read_data),
    .memc__dma__read_data_valid(memc__dma__read_data_valid),
    .ldst__memc__request(ldst__memc__request),
    .memc__ldst__granted(memc__ldst__granted),
    .ldst__memc__released(ldst__memc__released),
    .ldst__memc__write_valid(ldst__memc__write_valid),
    .ldst__memc__write_address(ldst__memc__write_address),
    .ldst__memc__write_data(ldst__memc__write_data),
    .ldst__memc__read_valid(ldst__memc__read_valid),
    .ldst__memc__read_address(ldst__memc__read_address),
    .memc__ldst__read_data(memc__ldst__read_data),
    .memc__ldst__read_data_valid(memc__ldst__read_data_valid),
    .memc__sram__cs(memc__sram__cs),
    .memc__sram__we(memc__sram__we),
    .memc__sram__addr(memc__sram__addr),
    .memc__sram__wdata(memc__sram__wdata),
    .sram__memc__rdata(sram__memc__rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sram_mem [0:255];
  logic [DW-1:0] sram_pipe [0:L-1];
  logic [DW-1:0] exp_mem [0:255];
  assign sram__memc__rdata = sram_pipe[L-1];

  always @(posedge clk) begin
    if (memc__sram__cs && memc__sram__we) sram_mem[memc__sram__addr[7:0]] <= memc__sram__wdata;
    sram_pipe[0] <= (memc__sram__cs && !memc__sram__we) ? sram_mem[memc__sram__addr[7:0]] : 32'hx;
    for (int i = 1; i < L; i++) sram_pipe[i] <= sram_pipe[i-1];
  end

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } lexp_t;

  logic [DW-1:0] dma_q[$];
  lexp_t         ldst_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    dma__memc__write_valid    = 1'b0;
    dma__memc__read_valid     = 1'b0;
    ldst__memc__write_valid   = 1'b0;
    ldst__memc__read_valid    = 1'b0;
    ldst__memc__released      = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {25'b0, memc__sram__cs, memc__sram__we, memc__dma__write_ready,
        memc__dma__read_ready, memc__dma__read_data_valid, memc__ldst__granted,
        memc__ldst__read_data_valid}, 32'h0);
    chk({tag, "_addr"}, {8'b0, memc__sram__addr}, 32'h0);
    chk({tag, "_wdata"}, memc__sram__wdata, 32'h0);
    chk({tag, "_dma_rdata"}, memc__dma__read_data, 32'h0);
    chk({tag, "_ldst_rdata"}, memc__ldst__read_data, 32'h0);
  endtask

  // Return monitor: every valid must match the oldest expectation.
  always @(negedge clk) begin
    lexp_t e;
    #2;
    if (!reset_poweron) begin
      if (memc__dma__read_data_valid) begin
        if (dma_q.size() == 0) chk("dma_spurious_valid", 32'h1, 32'h0);
        else chk("dma_rdata", memc__dma__read_data, dma_q.pop_front());
      end
      if (memc__ldst__read_data_valid) begin
        if (ldst_q.size() == 0) chk("ldst_spurious_valid", 32'h1, 32'h0);
        else begin
          e = ldst_q.pop_front();
          chk("ldst_rdata", memc__ldst__read_data, e.d);
          chk("ldst_latency", cyc, e.c);
        end
      end
    end
  end

  initial begin
    int idx;
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = '0;
      exp_mem[i]  = '0;
    end
    for (int i = 0; i < L; i++) sram_pipe[i] = '0;
    reset_poweron = 1'b1;
    clear_inputs();
    dma__memc__read_pause     = 1'b0;
    ldst__memc__request       = 1'b0;
    dma__memc__write_address  = '0;
    dma__memc__write_data     = '0;
    dma__memc__read_address   = '0;
    ldst__memc__write_address = '0;
    ldst__memc__write_data    = '0;
    ldst__memc__read_address  = '0;
    step(3);
    chk_all_zero("reset");
    @(negedge clk);
    reset_poweron = 1'b0;
    #1;
    chk("post_reset_wr_ready", memc__dma__write_ready, 1);
    chk("post_reset_rd_ready", memc__dma__read_ready, 1);
    chk("post_reset_granted", memc__ldst__granted, 0);

    // Single write then read, latency MEM_RD_LATENCY+1 from accept.
    @(negedge clk);
    dma__memc__write_valid = 1'b1; dma__memc__write_address = 24'h10; dma__memc__write_data = 32'hA5A5;
    #1;
    chk("t1_wr_ready", memc__dma__write_ready, 1);
    chk("t1_cs_we", {memc__sram__cs, memc__sram__we}, 2'b11);
    chk("t1_addr", {8'b0, memc__sram__addr}, 32'h10);
    exp_mem[8'h10] = 32'hA5A5;
    @(negedge clk);
    clear_inputs();
    dma__memc__read_valid = 1'b1; dma__memc__read_address = 24'h10;
    #1;
    chk("t1_rd_ready", memc__dma__read_ready, 1);
    chk("t1_rd_cs_we", {memc__sram__cs, memc__sram__we}, 2'b10);
    dma_q.push_back(exp_mem[8'h10]);
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      clear_inputs();
      #1;
      chk("t1_valid_timing", memc__dma__read_data_valid, (k == L + 1));
    end

    // Round-robin on conflict, starting with write.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dma__memc__write_valid = 1'b1; dma__memc__write_address = 24'h30 + i;
      dma__memc__write_data = 32'h100 + i;
      dma__memc__read_valid = 1'b1; dma__memc__read_address = 24'h10;
      #1;
      chk("t2_we", memc__sram__we, (i % 2 == 0));
      chk("t2_wr_ready", memc__dma__write_ready, (i % 2 == 0));
      chk("t2_rd_ready", memc__dma__read_ready, (i % 2 == 1));
      if (memc__dma__write_ready) exp_mem[8'h30 + i] = 32'h100 + i;
      if (memc__dma__read_ready) dma_q.push_back(exp_mem[8'h10]);
    end
    @(negedge clk);
    clear_inputs();
    step(8);
    chk("t2_drained", dma_q.size(), 0);

    // Pause back-pressure with credit limit.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dma__memc__write_valid = 1'b1; dma__memc__write_address = i; dma__memc__write_data = 32'h50 + i;
      #1;
      chk("t3_wr_ready", memc__dma__write_ready, 1);
      exp_mem[i] = 32'h50 + i;
    end
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      clear_inputs();
      dma__memc__read_pause = 1'b1;
      dma__memc__read_valid = 1'b1; dma__memc__read_address = idx;
      #1;
      chk("t3_ready_paused", memc__dma__read_ready, (i < 4));
      chk("t3_valid_paused", memc__dma__read_data_valid, 0);
      if (memc__dma__read_ready) begin
        dma_q.push_back(exp_mem[idx]);
        idx++;
      end
    end
    for (int i = 0; i < 30 && idx < 6; i++) begin
      @(negedge clk);
      dma__memc__read_pause = 1'b0;
      dma__memc__read_address = idx;
      #1;
      if (memc__dma__read_ready) begin
        dma_q.push_back(exp_mem[idx]);
        idx++;
      end
    end
    chk("t3_all_accepted", idx, 6);
    @(negedge clk);
    clear_inputs();
    step(10);
    chk("t3_drained", dma_q.size(), 0);

    // ldst request while DMA reads are outstanding.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dma__memc__read_valid = 1'b1; dma__memc__read_address = i;
      ldst__memc__request = (i == 2);
      #1;
      chk("t4_rd_ready", memc__dma__read_ready, 1);
      dma_q.push_back(exp_mem[i]);
    end
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      clear_inputs();
      dma__memc__write_valid = (k < L + 2);
      dma__memc__write_address = 24'h40; dma__memc__write_data = 32'hDEAD;
      #1;
      chk("t4_granted", memc__ldst__granted, (k == L + 2));
      chk("t4_no_dma_access", memc__sram__cs, 0);
      if (k < L + 2) chk("t4_drain_wr_ready", memc__dma__write_ready, 0);
    end
    @(negedge clk);
    clear_inputs();
    ldst__memc__write_valid = 1'b1; ldst__memc__write_address = 24'h20; ldst__memc__write_data = 32'h77;
    #1;
    chk("t4_ldst_wr", {memc__sram__cs, memc__sram__we}, 2'b11);
    chk("t4_ldst_wr_addr", {8'b0, memc__sram__addr}, 32'h20);
    chk("t4_ldst_wdata", memc__sram__wdata, 32'h77);
    exp_mem[8'h20] = 32'h77;
    @(negedge clk);
    clear_inputs();
    ldst__memc__read_valid = 1'b1; ldst__memc__read_address = 24'h20;
    #1;
    chk("t4_ldst_rd", {memc__sram__cs, memc__sram__we}, 2'b10);
    ldst_q.push_back('{d: exp_mem[8'h20], c: cyc + L});
    @(negedge clk);
    clear_inputs();
    ldst__memc__released = 1'b1; ldst__memc__request = 1'b0;
    #1;
    chk("t4_granted_at_release", memc__ldst__granted, 1);
    @(negedge clk);
    clear_inputs();
    dma__memc__read_valid = 1'b1; dma__memc__read_address = 24'h20;
    #1;
    chk("t4_granted_after_release", memc__ldst__granted, 0);
    chk("t4_dma_ready_back", memc__dma__read_ready, 1);
    dma_q.push_back(exp_mem[8'h20]);
    @(negedge clk);
    clear_inputs();
    step(8);
    chk("t4_dma_drained", dma_q.size(), 0);
    chk("t4_ldst_drained", ldst_q.size(), 0);

    // Ungranted ldst accesses are ignored.
    @(negedge clk);
    ldst__memc__write_valid = 1'b1; ldst__memc__write_address = 24'h10; ldst__memc__write_data = 32'hBAD;
    ldst__memc__read_valid = 1'b1; ldst__memc__read_address = 24'h10;
    #1;
    chk("t5_no_cs", memc__sram__cs, 0);
    @(negedge clk);
    clear_inputs();
    dma__memc__read_valid = 1'b1; dma__memc__read_address = 24'h10;
    #1;
    chk("t5_rd_ready", memc__dma__read_ready, 1);
    dma_q.push_back(exp_mem[8'h10]);
    @(negedge clk);
    clear_inputs();
    step(6);
    chk("t5_drained", dma_q.size(), 0);

    // Reset with 2 queued and 1 in-flight read.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dma__memc__read_pause = 1'b1;
      dma__memc__read_valid = 1'b1; dma__memc__read_address = i;
      #1;
      chk("t6_rd_ready", memc__dma__read_ready, 1);
      dma_q.push_back(exp_mem[i]);
    end
    @(negedge clk);
    clear_inputs();
    step(L - 2);
    @(negedge clk);
    reset_poweron = 1'b1;
    dma__memc__write_valid = 1'b1; dma__memc__write_address = 24'h5; dma__memc__write_data = 32'h1;
    #1;
    chk_all_zero("t6_reset");
    dma_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_poweron = 1'b0;
    clear_inputs();
    dma__memc__read_pause = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("t6_no_stale", memc__dma__read_data_valid, 0);
    end
    @(negedge clk);
    dma__memc__read_valid = 1'b1; dma__memc__read_address = 24'h5;
    #1;
    chk("t6_rd_ready", memc__dma__read_ready, 1);
    dma_q.push_back(exp_mem[5]);
    @(negedge clk);
    clear_inputs();
    step(6);
    chk("t6_drained", dma_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
